// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: digit-serial BCD A - B via 9's-complement add, decoded to sign-magnitude
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only in IDLE
//   A, B   packed BCD minuend / subtrahend, digit 0 in bits [3:0]
//   bin    borrow in (only when BCD_SUB_BORROW_IN_EN is defined)
//   busy   high while in SUB or FIX
//   done   one-cycle pulse when diff/neg are valid
//   diff   magnitude of A - B (packed BCD)
//   neg    1 when A - B < 0 (never for a zero magnitude)
//   err    1 when any captured digit of A or B exceeds 9
//
// Optional feature macro: BCD_SUB_BORROW_IN_EN (adds the bin port, result = A - B - bin).
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] A,
    input  logic [4*DIGITS-1:0] B,
`ifdef BCD_SUB_BORROW_IN_EN
    input  logic                bin,
`endif
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] diff,
    output logic                neg,
    output logic                err
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;

    state_t          state, nxt;
    logic [W-1:0]    a_r, b_r, sum_r, res_r;
    logic [CW-1:0]   cnt;
    logic            carry, cout, inc, bin_r, bin_in, bad, last;
    logic [4:0]      s, f_base, t;
    logic            s_gt, t_gt;
    logic [3:0]      s_dig, t_dig;

`ifdef BCD_SUB_BORROW_IN_EN
    assign bin_in = bin;
`else
    assign bin_in = 1'b0;
`endif

    assign last = cnt == CW'(DIGITS - 1);

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) bad = 1'b1;
    end

    // SUB digit: A_i + (9 - B_i) + carry, decimal-adjusted
    assign s     = {1'b0, a_r[3:0]} + (5'd9 - {1'b0, b_r[3:0]}) + {4'd0, carry};
    assign s_gt  = s > 5'd9;
    assign s_dig = s_gt ? 4'(s - 5'd10) : s[3:0];

    // FIX digit: end-around increment (cout=1) or recomplement plus borrow (cout=0)
    assign f_base = cout ? {1'b0, sum_r[3:0]} : 5'd9 - {1'b0, sum_r[3:0]};
    assign t      = f_base + {4'd0, inc};
    assign t_gt   = t > 5'd9;
    assign t_dig  = t_gt ? 4'(t - 5'd10) : t[3:0];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? SUB : IDLE;
            SUB:     nxt = last ? FIX : SUB;
            FIX:     nxt = last ? DONE : FIX;
            default: nxt = IDLE;
        endcase
    end

    always_comb busy = state == SUB || state == FIX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
            res_r <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            cout  <= 1'b0;
            inc   <= 1'b0;
            bin_r <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            neg   <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_r   <= A;
                    b_r   <= B;
                    bin_r <= bin_in;
                    // Plain 9's-complement add; the +1 arrives as the end-around carry in FIX
                    carry <= 1'b0;
                    cnt   <= '0;
                    err   <= bad;
                end
                SUB: begin
                    a_r   <= a_r >> 4;
                    b_r   <= b_r >> 4;
                    sum_r <= (sum_r >> 4) | (W'(s_dig) << (W - 4));
                    carry <= s_gt;
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        cout <= s_gt;
                        inc  <= s_gt ? ~bin_r : bin_r;
                    end
                end
                FIX: begin
                    sum_r <= sum_r >> 4;
                    res_r <= (res_r >> 4) | (W'(t_dig) << (W - 4));
                    inc   <= t_gt;
                    cnt   <= last ? '0 : cnt + 1'b1;
                end
                default: begin
                    // Result is registered on leaving DONE so done appears after edge 2*DIGITS+1
                    done <= 1'b1;
                    diff <= err ? '0 : res_r;
                    neg  <= !err && !cout && |res_r;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb_bcd_serial_subtractor: directed self-checking bench for bcd_serial_subtractor (DIGITS=4)
module tb_bcd_serial_subtractor;
    logic        clk = 1'b0;
    logic        rst_n, start, bin_s;
    logic [15:0] A, B;
    logic        busy, done, neg, err;
    logic [15:0] diff;
    int          passed = 0;
    int          total = 0;

    bcd_serial_subtractor #(.DIGITS(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .A(A),
        .B(B),
`ifdef BCD_SUB_BORROW_IN_EN
        .bin(bin_s),
`endif
        .busy(busy),
        .done(done),
        .diff(diff),
        .neg(neg),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_done(input string tag, input int n0, input logic [15:0] ed,
                             input logic en, input logic ee);
        int n;
        n = n0;
        while (!done && n < 30) begin
            @(posedge clk);
            #1 n++;
        end
        chk({tag, "_lat"}, n, 9);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_neg"}, neg, en);
        chk({tag, "_err"}, err, ee);
        @(posedge clk);
        #1 chk({tag, "_pulse"}, done, 0);
    endtask

    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic bn, input logic [15:0] ed, input logic en, input logic ee);
        A = a;
        B = b;
        bin_s = bn;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_errcap"}, err, ee);
        wait_done(tag, 0, ed, en, ee);
    endtask

    initial begin
        int seen;
        logic [15:0] prev;
        rst_n = 1'b0;
        start = 1'b0;
        bin_s = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_neg", neg, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("t1", 16'h0052, 16'h0017, 1'b0, 16'h0035, 1'b0, 1'b0);
        run("t2a", 16'h0017, 16'h0052, 1'b0, 16'h0035, 1'b1, 1'b0);
        run("t2b", 16'h0000, 16'h9999, 1'b0, 16'h9999, 1'b1, 1'b0);
        run("t2c", 16'h9999, 16'h0000, 1'b0, 16'h9999, 1'b0, 1'b0);
        run("t3a", 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0);
        run("t3b", 16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0);
        run("t3c", 16'h0500, 16'h0499, 1'b0, 16'h0001, 1'b0, 1'b0);
        run("t3d", 16'h0499, 16'h0500, 1'b0, 16'h0001, 1'b1, 1'b0);
        run("t4a", 16'h00A3, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
        run("t4b", 16'h0001, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0);

        // start during SUB is ignored; diff stays stale until done
        prev = diff;
        A = 16'h0052;
        B = 16'h0017;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("t5_stale", diff, prev);
        @(posedge clk);
        #1;
        A = 16'h9999;
        B = 16'h0000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t5a", 2, 16'h0035, 1'b0, 1'b0);

        // reset during FIX aborts with no done pulse
        A = 16'h0017;
        B = 16'h0052;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("t5_infix", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5r_busy", busy, 0);
        chk("t5r_diff", diff, 0);
        chk("t5r_neg", neg, 0);
        chk("t5r_err", err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
        chk("t5r_nodone", seen, 0);
        run("t5b", 16'h0052, 16'h0017, 1'b0, 16'h0035, 1'b0, 1'b0);

`ifdef BCD_SUB_BORROW_IN_EN
        run("t6a", 16'h0050, 16'h0050, 1'b1, 16'h0001, 1'b1, 1'b0);
        run("t6b", 16'h0051, 16'h0050, 1'b1, 16'h0000, 1'b0, 1'b0);
        run("t6c", 16'h0052, 16'h0017, 1'b1, 16'h0034, 1'b0, 1'b0);
        run("t6d", 16'h1000, 16'h0000, 1'b1, 16'h0999, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
